// File: rtl/hmac_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hmac_arb_pkg
// Purpose  : Shared definitions for the HMAC stream arbiter: FSM state
//            encoding, counter widths and a saturating-increment helper.
// Revision : 1.0 - initial release
// ============================================================================
package hmac_arb_pkg;

    localparam int BEAT_CNT_W    = 16;
    localparam int TIMEOUT_CNT_W = 13;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE     = 2'd0;
    localparam arb_state_t STREAM   = 2'd1;
    localparam arb_state_t WAIT_RES = 2'd2;
    localparam arb_state_t RESP     = 2'd3;

    // Beat counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [BEAT_CNT_W-1:0] sat_inc(input logic [BEAT_CNT_W-1:0] v);
        return (v == {BEAT_CNT_W{1'b1}}) ? v : v + BEAT_CNT_W'(1);
    endfunction

endpackage : hmac_arb_pkg
`default_nettype wire

// File: rtl/hmac_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : hmac_stream_arbiter_if
// Purpose  : Bundles the requester streams, the shared HMAC s_axis link and
//            the verdict/result signals of the HMAC stream arbiter.
// Ports    : req_tvalid/tready/tdata/tlast  - N_REQ requester lanes
//            m_axis_tvalid/tready/tdata/tlast - link to the HMAC unit
//            auth_done/auth_err             - verdict from the HMAC unit
//            res_valid/res_err              - verdict routed to requesters
// Modports : master - the arbiter (drives the m_axis link and results)
//            slave  - the environment (requesters + HMAC unit)
// Revision : 1.0 - initial release
// ============================================================================
interface hmac_stream_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
) ();

    logic [N_REQ-1:0]        req_tvalid;
    logic [N_REQ-1:0]        req_tready;
    logic [N_REQ*DATA_W-1:0] req_tdata;
    logic [N_REQ-1:0]        req_tlast;

    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic [DATA_W-1:0]       m_axis_tdata;
    logic                    m_axis_tlast;

    logic                    auth_done;
    logic                    auth_err;

    logic [N_REQ-1:0]        res_valid;
    logic                    res_err;

    modport master (
        input  req_tvalid, req_tdata, req_tlast, m_axis_tready, auth_done, auth_err,
        output req_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, res_valid, res_err
    );

    modport slave (
        output req_tvalid, req_tdata, req_tlast, m_axis_tready, auth_done, auth_err,
        input  req_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, res_valid, res_err
    );

endinterface : hmac_stream_arbiter_if
`default_nettype wire

// File: rtl/hmac_stream_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_select
// Purpose  : Combinational round-robin picker. Returns the first set request
//            found searching upward from i_ptr+1 with wrap-around, so the
//            lane at i_ptr has the lowest priority.
// Ports    : i_req - request vector     i_ptr - last granted index
//            o_gnt - one-hot grant      o_idx - grant index
//            o_any - at least one request is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_select #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        // k = N_REQ wraps back to i_ptr itself, so the previous owner is
        // still served when it is the only requester.
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = ID_W'((int'(i_ptr) + k) % N_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule : rr_select
`default_nettype wire

// File: rtl/hmac_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hmac_stream_arbiter
// Purpose  : Shares one HMAC unit s_axis port between N_REQ stream
//            requesters. Whole frames are granted round-robin; the grant is
//            held through tlast and until the unit returns a verdict, which
//            is routed back to the owner as a one-cycle res_valid pulse.
// Ports    : s_axis_aclk   - stream clock
//            s_axis_areset - asynchronous active-high reset
//            bus           - requester lanes, m_axis link, verdict, results
//            grant_id      - current/last owner index
//            busy          - FSM not in IDLE
//            beat_cnt      - beats forwarded in current/last frame
//            timeout_evt   - verdict watchdog expiry pulse (optional)
// Options  : HMAC_ARB_TIMEOUT_EN - adds the WAIT_RES watchdog and the
//            timeout_evt port; without it WAIT_RES waits forever.
// Revision : 1.0 - initial release
// ============================================================================
module hmac_stream_arbiter
    import hmac_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 32,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_areset,
    hmac_stream_arbiter_if.master bus,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy,
    output logic [BEAT_CNT_W-1:0] beat_cnt
`ifdef HMAC_ARB_TIMEOUT_EN
    ,
    output logic                  timeout_evt
`endif
);

    if (ID_W != $clog2(N_REQ) || TIMEOUT_CYCLES < 2 ||
        TIMEOUT_CYCLES > (2 ** TIMEOUT_CNT_W)) begin : g_param_check
        $error("hmac_stream_arbiter: inconsistent ID_W/N_REQ or TIMEOUT_CYCLES");
    end

    arb_state_t            r_state;
    logic [ID_W-1:0]       r_grant_id;
    logic [N_REQ-1:0]      r_grant_oh;
    logic [ID_W-1:0]       r_ptr;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;
    logic [N_REQ-1:0]      r_res_valid;
    logic                  r_res_err;

    logic [N_REQ-1:0]      w_sel_gnt;
    logic [ID_W-1:0]       w_sel_idx;
    logic                  w_sel_any;
    logic                  w_in_stream;
    logic                  w_m_tvalid;
    logic                  w_m_tlast;
    logic                  w_hs;
    logic                  w_verdict;

    rr_select #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_select (
        .i_req (bus.req_tvalid),
        .i_ptr (r_ptr),
        .o_gnt (w_sel_gnt),
        .o_idx (w_sel_idx),
        .o_any (w_sel_any)
    );

    // Pass-through of the granted lane only while streaming; every other
    // state presents an idle link and back-pressures all requesters.
    assign w_in_stream       = (r_state == STREAM);
    assign w_m_tvalid        = w_in_stream & |(bus.req_tvalid & r_grant_oh);
    assign w_m_tlast         = w_in_stream & |(bus.req_tlast & r_grant_oh);
    assign w_hs              = w_m_tvalid & bus.m_axis_tready;
    assign w_verdict         = bus.auth_done | bus.auth_err;

    assign bus.m_axis_tvalid = w_m_tvalid;
    assign bus.m_axis_tlast  = w_m_tlast;
    assign bus.m_axis_tdata  = w_in_stream ? bus.req_tdata[r_grant_id*DATA_W +: DATA_W]
                                           : '0;
    assign bus.req_tready    = w_in_stream ? (r_grant_oh & {N_REQ{bus.m_axis_tready}})
                                           : '0;

`ifdef HMAC_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_CNT_W-1:0] c_wd_limit = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_CNT_W-1:0] r_wd_cnt;
    logic                     r_timeout_evt;
`endif

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_state       <= IDLE;
            r_grant_id    <= '0;
            r_grant_oh    <= '0;
            r_ptr         <= ID_W'(N_REQ - 1);
            r_beat_cnt    <= '0;
            r_res_valid   <= '0;
            r_res_err     <= 1'b0;
`ifdef HMAC_ARB_TIMEOUT_EN
            r_wd_cnt      <= '0;
            r_timeout_evt <= 1'b0;
`endif
        end else begin
            r_res_valid   <= '0;
`ifdef HMAC_ARB_TIMEOUT_EN
            r_timeout_evt <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_sel_any) begin
                        r_grant_id <= w_sel_idx;
                        r_grant_oh <= w_sel_gnt;
                        r_ptr      <= w_sel_idx;
                        r_beat_cnt <= '0;
                        r_state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_hs) begin
                        r_beat_cnt <= sat_inc(r_beat_cnt);
                        if (w_m_tlast) begin
                            r_state  <= WAIT_RES;
`ifdef HMAC_ARB_TIMEOUT_EN
                            r_wd_cnt <= '0;
`endif
                        end
                    end
                end
                WAIT_RES: begin
                    // A real verdict beats a simultaneous watchdog expiry;
                    // err wins when the unit flags both.
                    if (w_verdict) begin
                        r_res_err   <= bus.auth_err;
                        r_res_valid <= r_grant_oh;
                        r_state     <= RESP;
                    end
`ifdef HMAC_ARB_TIMEOUT_EN
                    else if (r_wd_cnt == c_wd_limit) begin
                        r_res_err     <= 1'b1;
                        r_res_valid   <= r_grant_oh;
                        r_timeout_evt <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + TIMEOUT_CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant_id      = r_grant_id;
    assign busy          = (r_state != IDLE);
    assign beat_cnt      = r_beat_cnt;
    assign bus.res_valid = r_res_valid;
    assign bus.res_err   = r_res_err;
`ifdef HMAC_ARB_TIMEOUT_EN
    assign timeout_evt   = r_timeout_evt;
`endif

endmodule : hmac_stream_arbiter
`default_nettype wire

// File: tb/tb_hmac_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hmac_stream_arbiter
// Purpose  : Self-checking bench for hmac_stream_arbiter. Frames are queued
//            per requester lane; expected m_axis beats and per-frame results
//            go into scoreboard queues in expected grant order and are
//            popped as the DUT produces them. A small HMAC model answers
//            each tlast with a scripted verdict.
// Options  : HMAC_ARB_TIMEOUT_EN - also exercises the verdict watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hmac_stream_arbiter;
    import hmac_arb_pkg::*;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int ID_W   = 2;

    // Verdict codes for the HMAC model.
    localparam int V_DONE = 0;
    localparam int V_ERR  = 1;
    localparam int V_NONE = 2;
    localparam int V_BOTH = 3;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  lane;
    } beat_t;

    typedef struct packed {
        logic [3:0] vec;
        logic       err;
        logic       tmo;
    } res_t;

    logic                  s_axis_aclk = 1'b0;
    logic                  s_axis_areset = 1'b1;
    logic [ID_W-1:0]       grant_id;
    logic                  busy;
    logic [BEAT_CNT_W-1:0] beat_cnt;
`ifdef HMAC_ARB_TIMEOUT_EN
    logic                  timeout_evt;
`endif

    hmac_stream_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    hmac_stream_arbiter #(
        .N_REQ          (N_REQ),
        .DATA_W         (DATA_W),
        .ID_W           (ID_W),
        .TIMEOUT_CYCLES (4096)
    ) dut (
        .s_axis_aclk   (s_axis_aclk),
        .s_axis_areset (s_axis_areset),
        .bus           (bus),
        .grant_id      (grant_id),
        .busy          (busy),
        .beat_cnt      (beat_cnt)
`ifdef HMAC_ARB_TIMEOUT_EN
        ,
        .timeout_evt   (timeout_evt)
`endif
    );

    always #5 s_axis_aclk = ~s_axis_aclk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          frame_seq = 0;
    beat_t       lane_q [N_REQ][$];
    beat_t       exp_beats [$];
    res_t        exp_res [$];
    int          verdict_q [$];
    logic [N_REQ-1:0] lane_hs = '0;
    logic        m_last_hs = 1'b0;
    bit          gap_en = 1'b0;
    bit          rdy_toggle = 1'b0;
    bit          stray_req = 1'b0;
    bit          pend = 1'b0;
    int          pend_dly = 0;
    int          pend_verdict = 0;
    int          last_hs_cyc = 0;
    int          res_cyc = 0;

    task automatic push_frame(input int lane, input int nbeats, input int verdict);
        beat_t bt;
        res_t  r;
        for (int b = 0; b < nbeats; b++) begin
            bt.data = {8'(lane), 8'(frame_seq), 16'(b)};
            bt.last = (b == nbeats - 1);
            bt.lane = 2'(lane);
            lane_q[lane].push_back(bt);
            exp_beats.push_back(bt);
        end
        r.vec = 4'b0001 << lane;
        r.err = (verdict != V_DONE);
        r.tmo = (verdict == V_NONE);
        exp_res.push_back(r);
        verdict_q.push_back(verdict);
        frame_seq++;
    endtask

    function automatic bit outstanding();
        bit o;
        o = (exp_beats.size() != 0) || (exp_res.size() != 0) || pend;
        for (int i = 0; i < N_REQ; i++)
            if (lane_q[i].size() != 0) o = 1'b1;
        return o;
    endfunction

    task automatic flush_all();
        for (int i = 0; i < N_REQ; i++) lane_q[i].delete();
        exp_beats.delete();
        exp_res.delete();
        verdict_q.delete();
        pend = 1'b0;
        lane_hs = '0;
        m_last_hs = 1'b0;
        bus.req_tvalid = '0;
        bus.req_tlast  = '0;
        bus.req_tdata  = '0;
        bus.auth_done  = 1'b0;
        bus.auth_err   = 1'b0;
    endtask

    // One clock: scoreboard checks at the falling edge, then drive the
    // requesters and the HMAC model 1 ns after the rising edge.
    task automatic tick();
        beat_t eb;
        res_t  er;
        logic  tmo_obs;
        logic [N_REQ-1:0] td_v;
        logic [N_REQ-1:0] tl_v;
        logic [N_REQ*DATA_W-1:0] td;
        beat_t fb;

        @(negedge s_axis_aclk);
        cyc++;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            checks++;
            if (exp_beats.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected: got data=%h last=%b, expected no beat", bus.m_axis_tdata, bus.m_axis_tlast);
            end else begin
                eb = exp_beats.pop_front();
                if ({bus.m_axis_tdata, bus.m_axis_tlast, grant_id} !== {eb.data, eb.last, eb.lane}) begin
                    failures++;
                    $display("FAIL beat: got data=%h last=%b grant=%0d, expected data=%h last=%b grant=%0d",
                             bus.m_axis_tdata, bus.m_axis_tlast, grant_id, eb.data, eb.last, eb.lane);
                end
            end
        end
        if (busy) begin
            checks++;
            if ((bus.req_tready & ~(4'b0001 << grant_id)) !== 4'b0000) begin
                failures++;
                $display("FAIL tready_exclusive: got req_tready=%b grant=%0d, expected only granted lane", bus.req_tready, grant_id);
            end
        end
`ifdef HMAC_ARB_TIMEOUT_EN
        tmo_obs = timeout_evt;
`else
        tmo_obs = 1'b0;
`endif
        if (bus.res_valid !== 4'b0000 || tmo_obs !== 1'b0) begin
            checks++;
            res_cyc = cyc;
            if (exp_res.size() == 0) begin
                failures++;
                $display("FAIL result_unexpected: got res_valid=%b err=%b tmo=%b, expected none", bus.res_valid, bus.res_err, tmo_obs);
            end else begin
                er = exp_res.pop_front();
                if ({bus.res_valid, bus.res_err, tmo_obs} !== {er.vec, er.err, er.tmo}) begin
                    failures++;
                    $display("FAIL result: got res_valid=%b err=%b tmo=%b, expected res_valid=%b err=%b tmo=%b",
                             bus.res_valid, bus.res_err, tmo_obs, er.vec, er.err, er.tmo);
                end
            end
        end
        lane_hs   = bus.req_tvalid & bus.req_tready;
        m_last_hs = bus.m_axis_tvalid & bus.m_axis_tready & bus.m_axis_tlast;
        if (m_last_hs) last_hs_cyc = cyc;

        @(posedge s_axis_aclk);
        #1;
        for (int i = 0; i < N_REQ; i++)
            if (lane_hs[i] && lane_q[i].size() != 0) void'(lane_q[i].pop_front());
        td_v = '0;
        tl_v = '0;
        td   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (lane_q[i].size() != 0 && !(gap_en && (cyc % 5) == 2)) begin
                fb = lane_q[i][0];
                td_v[i] = 1'b1;
                tl_v[i] = fb.last;
                td[i*DATA_W +: DATA_W] = fb.data;
            end
        end
        bus.req_tvalid    = td_v;
        bus.req_tlast     = tl_v;
        bus.req_tdata     = td;
        bus.m_axis_tready = rdy_toggle ? ((cyc % 3) != 1) : 1'b1;

        bus.auth_done = 1'b0;
        bus.auth_err  = 1'b0;
        if (stray_req) begin
            bus.auth_done = 1'b1;
            stray_req = 1'b0;
        end
        if (pend) begin
            if (pend_dly == 0) begin
                pend = 1'b0;
                if (pend_verdict == V_DONE || pend_verdict == V_BOTH) bus.auth_done = 1'b1;
                if (pend_verdict == V_ERR  || pend_verdict == V_BOTH) bus.auth_err  = 1'b1;
            end else begin
                pend_dly--;
            end
        end
        if (m_last_hs) begin
            pend = 1'b1;
            pend_dly = 2;
            pend_verdict = (verdict_q.size() != 0) ? verdict_q.pop_front() : V_DONE;
        end
    endtask

    task automatic drain(input int budget, output int used);
        used = 0;
        while (outstanding() && used < budget) begin
            tick();
            used++;
        end
    endtask

    task automatic do_reset();
        s_axis_areset = 1'b1;
        flush_all();
        tick();
        tick();
        #2 s_axis_areset = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, bus.req_tready,
             bus.res_valid, bus.res_err, grant_id, busy, beat_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got tvalid=%b tready=%b res=%b grant=%0d busy=%b beat_cnt=%0d, expected all 0",
                     bus.m_axis_tvalid, bus.req_tready, bus.res_valid, grant_id, busy, beat_cnt);
        end
        #2 s_axis_areset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_single_frame();
        int n;
        push_frame(0, 22, V_DONE);
        drain(300, n);
        checks++;
        if (n >= 300) begin failures++; $display("FAIL single_frame_timeout: got %0d cycles, expected < 300", n); end
        checks++;
        if (beat_cnt !== 16'd22) begin failures++; $display("FAIL single_beat_cnt: got %0d, expected 22", beat_cnt); end
        checks++;
        if ({busy, grant_id} !== {1'b0, 2'd0}) begin
            failures++;
            $display("FAIL single_end_state: got busy=%b grant=%0d, expected busy=0 grant=0", busy, grant_id);
        end
    endtask

    task automatic test_two_requesters();
        int n;
        do_reset();
        push_frame(1, 5, V_DONE);
        push_frame(3, 6, V_DONE);
        drain(300, n);
        checks++;
        if (n >= 300) begin failures++; $display("FAIL two_req_timeout: got %0d cycles, expected < 300", n); end
        checks++;
        if ({grant_id, beat_cnt} !== {2'd3, 16'd6}) begin
            failures++;
            $display("FAIL two_req_last: got grant=%0d beat_cnt=%0d, expected grant=3 beat_cnt=6", grant_id, beat_cnt);
        end
    endtask

    task automatic test_round_robin();
        int n;
        for (int f = 0; f < 8; f++) push_frame(f % 4, 3, (f % 2 == 0) ? V_DONE : V_ERR);
        drain(600, n);
        checks++;
        if (n >= 600) begin failures++; $display("FAIL rr_timeout: got %0d cycles, expected < 600", n); end
        checks++;
        if (grant_id !== 2'd3) begin failures++; $display("FAIL rr_last_grant: got %0d, expected 3", grant_id); end
    endtask

    task automatic test_stall_and_gaps();
        int n;
        gap_en = 1'b1;
        rdy_toggle = 1'b1;
        push_frame(2, 12, V_ERR);
        drain(400, n);
        gap_en = 1'b0;
        rdy_toggle = 1'b0;
        checks++;
        if (n >= 400) begin failures++; $display("FAIL stall_timeout: got %0d cycles, expected < 400", n); end
        checks++;
        if (beat_cnt !== 16'd12) begin failures++; $display("FAIL stall_beat_cnt: got %0d, expected 12", beat_cnt); end
    endtask

    task automatic test_stray_verdict();
        int n;
        // A verdict while IDLE must not produce a result.
        stray_req = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL stray_idle: got busy=%b, expected 0", busy); end
        push_frame(1, 8, V_ERR);
        n = 0;
        while (beat_cnt != 16'd3 && n < 100) begin tick(); n++; end
        stray_req = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, bus.res_valid} !== {1'b1, 4'b0000}) begin
            failures++;
            $display("FAIL stray_stream: got busy=%b res_valid=%b, expected busy=1 res_valid=0000", busy, bus.res_valid);
        end
        drain(300, n);
        checks++;
        if (beat_cnt !== 16'd8) begin failures++; $display("FAIL stray_beat_cnt: got %0d, expected 8", beat_cnt); end
    endtask

    task automatic test_both_verdict();
        int n;
        push_frame(0, 3, V_BOTH);
        drain(200, n);
        checks++;
        if (n >= 200) begin failures++; $display("FAIL both_timeout: got %0d cycles, expected < 200", n); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        push_frame(1, 20, V_DONE);
        n = 0;
        while (beat_cnt != 16'd10 && n < 100) begin tick(); n++; end
        checks++;
        if (beat_cnt !== 16'd10) begin failures++; $display("FAIL midrst_reach: got beat_cnt=%0d, expected 10", beat_cnt); end
        #2 s_axis_areset = 1'b1;
        #1;
        checks++;
        if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, bus.req_tready,
             bus.res_valid, bus.res_err, grant_id, busy, beat_cnt} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: got tvalid=%b tready=%b grant=%0d busy=%b beat_cnt=%0d, expected all 0",
                     bus.m_axis_tvalid, bus.req_tready, grant_id, busy, beat_cnt);
        end
        flush_all();
        tick();
        tick();
        #2 s_axis_areset = 1'b0;
        // Pointer must be back at N_REQ-1: lane 0 wins over lane 2.
        push_frame(0, 4, V_DONE);
        push_frame(2, 4, V_DONE);
        drain(300, n);
        checks++;
        if ({grant_id, beat_cnt} !== {2'd2, 16'd4}) begin
            failures++;
            $display("FAIL midrst_after: got grant=%0d beat_cnt=%0d, expected grant=2 beat_cnt=4", grant_id, beat_cnt);
        end
    endtask

`ifdef HMAC_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        push_frame(0, 2, V_NONE);
        drain(5000, n);
        checks++;
        if (n >= 5000) begin failures++; $display("FAIL timeout_budget: got %0d cycles, expected < 5000", n); end
        checks++;
        if (res_cyc - last_hs_cyc !== 4097) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles tlast->result, expected 4097", res_cyc - last_hs_cyc);
        end
    endtask
`endif

    initial begin
        bus.req_tvalid    = '0;
        bus.req_tdata     = '0;
        bus.req_tlast     = '0;
        bus.m_axis_tready = 1'b1;
        bus.auth_done     = 1'b0;
        bus.auth_err      = 1'b0;

        test_reset();
        test_single_frame();
        test_two_requesters();
        test_round_robin();
        test_stall_and_gaps();
        test_stray_verdict();
        test_both_verdict();
        test_reset_mid_frame();
`ifdef HMAC_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hmac_stream_arbiter
`default_nettype wire

// File: doc/hmac_stream_arbiter.md
Name: hmac_stream_arbiter

Overview:
- Shares one axi_hmac_unit AXI-Stream message port between N_REQ independent stream requesters.
- Grants whole frames round-robin: a grant is held from the first beat through tlast, then until the unit reports auth_done or auth_err.
- Routes that verdict back to the owning requester as a one-cycle result pulse.
- Sits between the requesters' stream sources and the HMAC unit's s_axis port, and is clocked by the same stream clock.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 32, stream data width; matches the HMAC unit.
- ID_W, 2, width of the grant index; must equal clog2(N_REQ).
- TIMEOUT_CYCLES, 4096, verdict watchdog limit; used only with HMAC_ARB_TIMEOUT_EN.

Ports:
- s_axis_aclk  in  1  stream clock; the only clock.
- s_axis_areset  in  1  asynchronous, active-high reset.
- req_tvalid  in  N_REQ  per-requester tvalid.
- req_tready  out  N_REQ  per-requester tready.
- req_tdata  in  N_REQ*DATA_W  requester data; requester i occupies [i*DATA_W +: DATA_W].
- req_tlast  in  N_REQ  per-requester tlast.
- m_axis_tvalid  out  1  to HMAC unit s_axis_tvalid.
- m_axis_tready  in  1  from HMAC unit s_axis_tready.
- m_axis_tdata  out  DATA_W  to HMAC unit s_axis_tdata.
- m_axis_tlast  out  1  to HMAC unit s_axis_tlast.
- auth_done  in  1  HMAC unit verdict: tag matched.
- auth_err  in  1  HMAC unit verdict: tag mismatch.
- res_valid  out  N_REQ  one-cycle verdict pulse, one bit per requester.
- res_err  out  1  verdict qualifier; 1 = fail; valid only with res_valid.
- grant_id  out  ID_W  index of the current or last owner.
- busy  out  1  high in any state other than IDLE.
- beat_cnt  out  16  number of beats forwarded in the current/last frame.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - State = IDLE; every output 0.
  - Round-robin pointer = N_REQ-1, so requester 0 has priority first.
  - beat_cnt = 0.
- States: IDLE, STREAM, WAIT_RES, RESP.
- IDLE:
  - If any req_tvalid is high, select the first set bit searching from pointer+1 with wrap-around.
  - Register the selection into grant_id, update the pointer to it, clear beat_cnt, go to STREAM.
  - All req_tready = 0 and m_axis_tvalid = 0 in IDLE, so the first beat passes one cycle after the grant.
- STREAM (combinational pass-through of the granted lane only):
  - m_axis_tvalid/tdata/tlast = the granted requester's tvalid/tdata/tlast.
  - req_tready[grant_id] = m_axis_tready; all other req_tready = 0.
  - On each handshake (m_axis_tvalid & m_axis_tready): beat_cnt increments, saturating at 0xFFFF.
  - A handshake with tlast set moves to WAIT_RES.
  - A zero-length frame is impossible: the tlast beat is always counted.
- WAIT_RES:
  - m_axis_tvalid = 0; all req_tready = 0.
  - On auth_done | auth_err: latch res_err = auth_err (if both are high, err wins), go to RESP.
- RESP (one cycle):
  - res_valid[grant_id] = 1, all other bits 0; res_err holds the latched value.
  - Next state IDLE; the new arbitration is evaluated in IDLE, so the minimum inter-frame gap is 2 cycles.
- Verdicts outside WAIT_RES (IDLE, STREAM, RESP) are ignored and do not change state.
- A requester dropping tvalid mid-frame stalls the frame; the grant is held indefinitely (no preemption).
- Reset mid-frame: immediate return to IDLE with all outputs 0. The HMAC unit is reset by the same reset net, so no partial frame survives.
- res_err is registered and holds its value until the next verdict; it is meaningful only when res_valid is high.

Optional Feature:
- Macro: HMAC_ARB_TIMEOUT_EN.
- Defined:
  - A 13-bit watchdog counter clears on entry to WAIT_RES and increments each cycle in WAIT_RES.
  - On reaching TIMEOUT_CYCLES-1 without a verdict: go to RESP with res_err = 1, and pulse output timeout_evt (1 bit, reset 0) for one cycle.
  - A verdict arriving in the same cycle as the timeout takes priority over the timeout.
- Undefined: timeout_evt port and counter are absent; WAIT_RES waits forever.

Decomposition:
- Shared package hmac_arb_pkg holds:
  - state encoding localparams (IDLE=0, STREAM=1, WAIT_RES=2, RESP=3);
  - BEAT_CNT_W=16;
  - TIMEOUT_CNT_W=13.
- One sub-module, rr_select: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any.

Test Plan:
- Single requester 0 sends a 22-beat frame (544-bit message + 160-bit tag), unit returns auth_done -> 22 beats appear on m_axis with tlast on beat 22; res_valid = 4'b0001, res_err = 0; beat_cnt = 22.
- Requesters 1 and 3 assert valid simultaneously after reset -> requester 1 served first, then 3; res_valid pulses 4'b0010, then 4'b1000; req_tready[3] stays 0 throughout frame 1.
- All four requesters continuously valid for 8 frames -> grant order 0,1,2,3,0,1,2,3.
- m_axis_tready toggled 1-0-1 and requester tvalid gaps mid-frame -> no beat duplicated or lost, tdata order preserved, beat_cnt exact; auth_err verdict gives res_err = 1.
- auth_done pulsed during STREAM, then auth_err in WAIT_RES -> the first pulse is ignored; result res_err = 1.
- Reset asserted at beat 10 of a frame -> all outputs 0 the same cycle; after release, requester 0 is granted first. With HMAC_ARB_TIMEOUT_EN and no verdict -> timeout_evt fires after 4096 cycles in WAIT_RES and res_err = 1.
